// File: rtl/disp_scan_pkg.sv
// Shared types, timing constants and helpers
// for the multiplexed display scanners.
package disp_scan_pkg;

  localparam int T10MS_50M = 500000;
  localparam int T1MS_50M  = 50000;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic active_lvl(input bit al);
    return al ? 1'b0 : 1'b1;
  endfunction

  function automatic logic inactive_lvl(input bit al);
    return al ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/digit_rr_pick.sv
// Rotating-priority finder: next enabled digit
// after the current one, plus lowest enabled digit.
module digit_rr_pick
  import disp_scan_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] cur,
  output logic [IW-1:0] nxt,
  output logic [IW-1:0] low,
  output logic          any
);

  logic hit;
  int   j;

  always_comb begin
    nxt = cur;
    low = '0;
    any = |mask;
    hit = 1'b0;
    j   = 0;
    for (int i = N - 1; i >= 0; i--)
      if (mask[i]) low = IW'(i);
    // k == N lands back on cur: sole enabled digit keeps its slot
    for (int k = 1; k <= N; k++) begin
      j = (int'(cur) + k) % N;
      if (!hit && mask[IW'(j)]) begin
        hit = 1'b1;
        nxt = IW'(j);
      end
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// N-digit common scan generator with dwell,
// anti-ghost blanking, enable mask and polarity.
module digit_scan_ctrl
  import disp_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_TICKS  = T10MS_50M,
  parameter int BLANK_TICKS = 1000,
  parameter bit ACTIVE_LOW  = 1'b1,
  localparam int IDX_W = clog2(NUM_DIGITS),
  localparam int CNT_W = clog2(SCAN_TICKS)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [NUM_DIGITS-1:0] Digit_En,
  output logic [NUM_DIGITS-1:0] Col_Scan_Sig,
  output logic [IDX_W-1:0]      Sel_Index,
  output logic                  Frame_Start
);

  localparam logic ACT   = active_lvl(ACTIVE_LOW);
  localparam logic INACT = inactive_lvl(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_TICKS);

  scan_state_e             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        sel_q, sel_d;
  logic [NUM_DIGITS-1:0]   col_q, col_d;
  logic                    fs_q, fs_d;

  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] low_idx;
  logic             any_en;

  digit_rr_pick #(
    .N  (NUM_DIGITS),
    .IW (IDX_W)
  ) u_pick (
    .mask (Digit_En),
    .cur  (sel_q),
    .nxt  (nxt_idx),
    .low  (low_idx),
    .any  (any_en)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    fs_d    = 1'b0;
    col_d   = {NUM_DIGITS{INACT}};
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_en) begin
          state_d = SCAN;
          sel_d   = low_idx;
          fs_d    = 1'b1;
        end
      end
      SCAN: begin
        if (!any_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          cnt_d = '0;
          sel_d = nxt_idx;
          fs_d  = (nxt_idx == low_idx);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // live mask gates the common so a disabled digit goes dark at once
        if (cnt_q >= BLANK && Digit_En[sel_q])
          col_d[sel_q] = ACT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      col_q   <= {NUM_DIGITS{INACT}};
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      col_q   <= col_d;
      fs_q    <= fs_d;
    end
  end

  assign Col_Scan_Sig = col_q;
  assign Sel_Index    = sel_q;
  assign Frame_Start  = fs_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl, both
// polarities driven from the same stimulus.
module tb_digit_scan_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic [3:0] Digit_En;
  logic [3:0] col, col_n;
  logic [1:0] sel, sel_n;
  logic       fs, fs_n;

  always #5 CLK = ~CLK;

  digit_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_TICKS  (8),
    .BLANK_TICKS (2),
    .ACTIVE_LOW  (1'b1)
  ) u_dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Digit_En     (Digit_En),
    .Col_Scan_Sig (col),
    .Sel_Index    (sel),
    .Frame_Start  (fs)
  );

  digit_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_TICKS  (8),
    .BLANK_TICKS (2),
    .ACTIVE_LOW  (1'b0)
  ) u_dut_n (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .Digit_En     (Digit_En),
    .Col_Scan_Sig (col_n),
    .Sel_Index    (sel_n),
    .Frame_Start  (fs_n)
  );

  typedef struct packed {
    logic [3:0] col;
    logic [1:0] sel;
    logic       fs;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_chk  = 0;
  int   n_fail = 0;
  event smp_ev;

  function automatic logic [3:0] act(input logic [1:0] s);
    logic [3:0] v;
    v = 4'b0001 << s;
    return ~v;
  endfunction

  task automatic chk(input string nm, input logic [3:0] a,
                     input logic [3:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b want %b", nm, $time, a, e);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK or smp_ev);
      if (q.size() > 0) begin
        me = q.pop_front();
        chk("col", col, me.col);
        chk("sel", {2'b0, sel}, {2'b0, me.sel});
        chk("fs", {3'b0, fs}, {3'b0, me.fs});
        chk("col_n", col_n, ~me.col);
        chk("sel_n", {2'b0, sel_n}, {2'b0, me.sel});
        chk("fs_n", {3'b0, fs_n}, {3'b0, me.fs});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pc(input logic [3:0] c, input logic [1:0] s,
                    input logic f);
    tick();
    q.push_back({c, s, f});
  endtask

  // one full 8-cycle slot as seen at the outputs; c0 is the
  // previous slot's common, still showing for one cycle
  task automatic slot(input logic [1:0] s, input logic f,
                      input logic [3:0] c0);
    pc(c0, s, f);
    pc(4'b1111, s, 1'b0);
    pc(4'b1111, s, 1'b0);
    for (int i = 0; i < 5; i++) pc(act(s), s, 1'b0);
  endtask

  initial begin
    RSTn     = 1'b0;
    Digit_En = 4'b0000;
    pc(4'b1111, 2'd0, 1'b0);
    pc(4'b1111, 2'd0, 1'b0);
    RSTn = 1'b1;
    pc(4'b1111, 2'd0, 1'b0);
    pc(4'b1111, 2'd0, 1'b0);

    Digit_En = 4'b1111;
    slot(2'd0, 1'b1, 4'b1111);
    slot(2'd1, 1'b0, 4'b1110);
    slot(2'd2, 1'b0, 4'b1101);
    slot(2'd3, 1'b0, 4'b1011);
    slot(2'd0, 1'b1, 4'b0111);
    slot(2'd1, 1'b0, 4'b1110);

    Digit_En = 4'b1010;
    slot(2'd3, 1'b0, 4'b1101);
    slot(2'd1, 1'b1, 4'b0111);
    slot(2'd3, 1'b0, 4'b1101);
    slot(2'd1, 1'b1, 4'b0111);

    Digit_En = 4'b0100;
    slot(2'd2, 1'b1, 4'b1111);
    slot(2'd2, 1'b1, 4'b1011);
    slot(2'd2, 1'b1, 4'b1011);

    Digit_En = 4'b1111;
    slot(2'd3, 1'b0, 4'b1011);
    slot(2'd0, 1'b1, 4'b0111);
    pc(4'b1110, 2'd1, 1'b0);
    pc(4'b1111, 2'd1, 1'b0);
    pc(4'b1111, 2'd1, 1'b0);
    pc(4'b1101, 2'd1, 1'b0);
    pc(4'b1101, 2'd1, 1'b0);
    Digit_En = 4'b1101;
    pc(4'b1111, 2'd1, 1'b0);
    pc(4'b1111, 2'd1, 1'b0);
    pc(4'b1111, 2'd1, 1'b0);
    slot(2'd2, 1'b0, 4'b1111);
    slot(2'd3, 1'b0, 4'b1011);
    slot(2'd0, 1'b1, 4'b0111);

    pc(4'b1110, 2'd2, 1'b0);
    pc(4'b1111, 2'd2, 1'b0);
    pc(4'b1111, 2'd2, 1'b0);
    pc(4'b1011, 2'd2, 1'b0);
    Digit_En = 4'b0000;
    for (int i = 0; i < 4; i++) pc(4'b1111, 2'd2, 1'b0);
    Digit_En = 4'b0001;
    slot(2'd0, 1'b1, 4'b1111);
    slot(2'd0, 1'b1, 4'b1110);

    Digit_En = 4'b0100;
    pc(4'b1111, 2'd2, 1'b1);
    pc(4'b1111, 2'd2, 1'b0);
    pc(4'b1111, 2'd2, 1'b0);
    pc(4'b1011, 2'd2, 1'b0);
    pc(4'b1011, 2'd2, 1'b0);
    pc(4'b1011, 2'd2, 1'b0);
    @(negedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    q.push_back({4'b1111, 2'd0, 1'b0});
    ->smp_ev;
    pc(4'b1111, 2'd0, 1'b0);
    pc(4'b1111, 2'd0, 1'b0);
    RSTn = 1'b1;
    slot(2'd2, 1'b1, 4'b1111);
    slot(2'd2, 1'b1, 4'b1011);

    @(negedge CLK);
    #1;
    chk("drain", 4'(q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end, want end before 100000");
    $fatal(1);
  end

endmodule
